// File: rtl/adder_pkg.sv
// adder_pkg: shared operand layout, widths and feeder states for the adder and its feeder
package adder_pkg;
  localparam int SUM_W = 10;
  localparam int OP_BYTES = 4;
  typedef struct packed {
    logic       cin;
    logic [7:0] w;
    logic [7:0] z;
    logic [7:0] y;
    logic [7:0] x;
  } operands_t;
  typedef enum logic [1:0] {COLLECT, HOLD, RESP} state_t;
endpackage

// File: rtl/adder.sv
// adder: registered sum x[3:2]+y+z+w+cin with zero flag, one cycle after ins
module adder
  import adder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [32:0]      ins,
  output logic [SUM_W-1:0] sm_r,
  output logic             sm_zero_r
);
  operands_t op;
  logic [SUM_W-1:0] sum;
  always_comb begin
    op = operands_t'(ins);
    sum = SUM_W'(op.x[3:2]) + SUM_W'(op.y) + SUM_W'(op.z) + SUM_W'(op.w) + SUM_W'(op.cin);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sm_r <= '0;
      sm_zero_r <= 1'b0;
    end else begin
      sm_r <= sum;
      sm_zero_r <= (sum == '0);
    end
endmodule

// File: rtl/adder_feeder.sv
// adder_feeder: gathers four operand bytes plus carry-in, holds them for the adder and returns its result
module adder_feeder
  import adder_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_cin,
  output logic             in_ready,
  output logic [32:0]      ins,
  input  logic [SUM_W-1:0] sm_r,
  input  logic             sm_zero_r,
  output logic             res_valid,
  output logic [SUM_W-1:0] res_sum,
  output logic             res_zero,
  input  logic             res_ready,
  output logic             busy
);
  localparam int WW = (LAT < 1) ? 1 : $clog2(LAT + 1);
  state_t state, state_nx;
  logic [1:0] cnt;
  logic [WW-1:0] wcnt;
  logic in_fire, last_byte, sample;
  always_comb begin
    in_fire = in_valid && in_ready;
    last_byte = in_fire && (cnt == 2'(OP_BYTES - 1));
    sample = (state == HOLD) && (wcnt == '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= COLLECT;
    else state <= state_nx;
  always_comb
    state_nx = last_byte                        ? HOLD    :
               sample                           ? RESP    :
               (state == RESP && res_ready)     ? COLLECT : state;
  always_comb begin
    in_ready = (state == COLLECT);
    res_valid = (state == RESP);
    busy = !(state == COLLECT && cnt == '0);
  end
  // ins stays frozen outside COLLECT because only accepted bytes write it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      wcnt <= '0;
      ins <= '0;
      res_sum <= '0;
      res_zero <= 1'b0;
    end else begin
      if (in_fire) begin
        ins[8*cnt +: 8] <= in_data;
        cnt <= cnt + 2'd1;
      end
      if (last_byte) begin
        ins[32] <= in_cin;
        wcnt <= WW'(LAT);
      end
      if (state == HOLD && wcnt != '0) wcnt <= wcnt - WW'(1);
      if (sample) begin
        res_sum <= sm_r;
        res_zero <= sm_zero_r;
      end
    end
endmodule
